// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: core-wide control bundle, ALUOp encodings and datapath width.
package id_ex_stage_pkg;
  localparam int XLEN = 64;
  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;
  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the ID instruction.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_valid,
  output logic       hazard
);
  always_comb hazard = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush and stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_mem_to_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_jump,
  input  logic [1:0]      id_alu_op,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_funct4,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic            ex_jump,
  output logic [1:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_funct4,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [31:0]     hazard_count
);
  ctrl_t ctrl_d, ctrl_q;
  logic valid_d, valid_q, hazard, stall, bubble;
  logic [XLEN-1:0] pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [4:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [3:0] funct4_d, funct4_q;
  logic [31:0] hazard_count_d, hazard_count_q;
  hazard_detect u_hazard_detect (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .ex_valid    (valid_q),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_valid    (id_valid),
    .hazard      (hazard)
  );
  // Flush wins over the stall: fetch is being redirected, so holding PC would be wrong.
  always_comb begin
    stall = hazard & ~flush;
    bubble = flush | hazard | ~id_valid;
    ctrl_d = bubble ? CTRL_BUBBLE : ctrl_t'{id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
                                            id_alu_src, id_reg_write, id_jump, id_alu_op};
    valid_d = ~bubble;
    rd_d = bubble ? 5'd0 : id_rd;
    pc_d = id_pc;
    rs1_data_d = id_rs1_data;
    rs2_data_d = id_rs2_data;
    imm_d = id_imm;
    rs1_d = id_rs1;
    rs2_d = id_rs2;
    funct4_d = id_funct4;
    hazard_count_d = (stall && hazard_count_q != '1) ? hazard_count_q + 32'd1 : hazard_count_q;
    pc_write = reset | ~stall;
    if_id_write = reset | ~stall;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      funct4_q <= '0;
      hazard_count_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      pc_q <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q <= imm_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q <= rd_d;
      funct4_q <= funct4_d;
      hazard_count_q <= hazard_count_d;
    end
  end
  assign ex_valid = valid_q;
  assign {ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump,
          ex_alu_op} = ctrl_q;
  assign ex_pc = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm = imm_q;
  assign ex_rs1 = rs1_q;
  assign ex_rs2 = rs2_q;
  assign ex_rd = rd_q;
  assign ex_funct4 = funct4_q;
  assign hazard_count = hazard_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random stimulus checked against a behavioural ID/EX model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic clk = 1'b0, reset, id_valid, flush;
  ctrl_t id_c;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_funct4;
  logic ex_valid, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jump;
  logic [1:0] ex_alu_op;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_funct4;
  logic pc_write, if_id_write;
  logic [31:0] hazard_count;
  int checks = 0, failures = 0;
  localparam ctrl_t RT = '{reg_write: 1'b1, alu_op: ALU_RTYPE, default: '0};
  localparam ctrl_t LD = '{mem_read: 1'b1, mem_to_reg: 1'b1, alu_src: 1'b1, reg_write: 1'b1,
                           alu_op: ALU_ADD, default: '0};
  // Reference state: what EX should hold, plus whether datapath fields are defined.
  logic m_valid, m_dk;
  ctrl_t m_ctrl;
  logic [4:0] m_rd, m_rs1, m_rs2;
  logic [63:0] m_pc, m_a, m_b, m_imm;
  logic [3:0] m_f4;
  longint unsigned m_cnt;
  logic seen_pw;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_branch(id_c.branch), .id_mem_read(id_c.mem_read), .id_mem_to_reg(id_c.mem_to_reg),
    .id_mem_write(id_c.mem_write), .id_alu_src(id_c.alu_src), .id_reg_write(id_c.reg_write),
    .id_jump(id_c.jump), .id_alu_op(id_c.alu_op),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct4(id_funct4), .flush(flush),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct4(ex_funct4),
    .pc_write(pc_write), .if_id_write(if_id_write), .hazard_count(hazard_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input ctrl_t c, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] d, input logic [63:0] a, input logic fl);
    id_valid = v; id_c = c; id_rs1 = r1; id_rs2 = r2; id_rd = d; id_rs1_data = a; flush = fl;
    id_rs2_data = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_pc = {$urandom, $urandom}; id_funct4 = 4'($urandom);
  endtask

  // One clock: check the combinational stall outputs, advance the model, check EX state.
  task automatic step();
    logic load_use, pw;
    #1;
    load_use = m_valid && m_ctrl.mem_read && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
    pw = reset || flush || !load_use;
    seen_pw = pc_write;
    chk("pc_write", {63'd0, pc_write}, {63'd0, pw});
    chk("if_id_write", {63'd0, if_id_write}, {63'd0, pw});
    if (reset) begin
      m_valid = 0; m_ctrl = '0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_pc = 0; m_a = 0; m_b = 0;
      m_imm = 0; m_f4 = 0; m_cnt = 0; m_dk = 1;
    end else begin
      if (load_use && !flush) m_cnt = (m_cnt >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
      if (flush || load_use || !id_valid) begin
        m_valid = 0; m_ctrl = '0; m_rd = 0; m_dk = 0;
      end else begin
        m_valid = 1; m_ctrl = id_c; m_rd = id_rd; m_rs1 = id_rs1; m_rs2 = id_rs2; m_pc = id_pc;
        m_a = id_rs1_data; m_b = id_rs2_data; m_imm = id_imm; m_f4 = id_funct4; m_dk = 1;
      end
    end
    @(posedge clk); #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    chk("ex_ctrl", {55'd0, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                    ex_reg_write, ex_jump, ex_alu_op}, {55'd0, m_ctrl});
    chk("ex_rd", {59'd0, ex_rd}, {59'd0, m_rd});
    chk("hazard_count", {32'd0, hazard_count}, m_cnt);
    if (m_dk) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_rs1_data", ex_rs1_data, m_a);
      chk("ex_rs2_data", ex_rs2_data, m_b);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_regs", {54'd0, ex_rs1, ex_rs2}, {54'd0, m_rs1, m_rs2});
      chk("ex_funct4", {60'd0, ex_funct4}, {60'd0, m_f4});
    end
  endtask

  initial begin
    m_valid = 0; m_dk = 0; m_ctrl = '0; m_rd = 0; m_cnt = 0;
    reset = 1;
    put(1, RT, 1, 2, 3, 64'h55, 0);
    step(); step();
    chk("rst_pcw", {63'd0, seen_pw}, 64'd1);
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    reset = 0;
    put(1, RT, 1, 2, 5, 64'h10, 0); step();
    chk("pt_rd", {59'd0, ex_rd}, 64'd5);
    chk("pt_data", ex_rs1_data, 64'h10);
    put(1, LD, 2, 0, 6, 64'h0, 0); step();
    put(1, RT, 6, 3, 8, 64'h20, 0); step();
    chk("lu_pcw", {63'd0, seen_pw}, 64'd0);
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    step();
    chk("lu_pcw2", {63'd0, seen_pw}, 64'd1);
    chk("lu_enter", {59'd0, ex_rd}, 64'd8);
    chk("lu_cnt", {32'd0, hazard_count}, 64'd1);
    put(1, LD, 2, 0, 0, 64'h0, 0); step();
    put(1, RT, 0, 0, 9, 64'h30, 0); step();
    chk("x0_pcw", {63'd0, seen_pw}, 64'd1);
    chk("x0_cnt", {32'd0, hazard_count}, 64'd1);
    put(1, LD, 2, 0, 7, 64'h0, 0); step();
    put(1, RT, 7, 1, 10, 64'h40, 1); step();
    chk("fl_pcw", {63'd0, seen_pw}, 64'd1);
    chk("fl_bubble", {63'd0, ex_valid}, 64'd0);
    chk("fl_cnt", {32'd0, hazard_count}, 64'd1);
    force dut.hazard_count_q = 32'hFFFF_FFFD;
    #1 release dut.hazard_count_q;
    m_cnt = 64'hFFFF_FFFD;
    for (int i = 0; i < 4; i++) begin
      put(1, LD, 1, 1, 11, 64'h0, 0); step();
      put(1, RT, 11, 2, 12, 64'h50, 0); step();
    end
    chk("sat", {32'd0, hazard_count}, 64'hFFFF_FFFF);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      put($urandom_range(0, 4) != 0, ctrl_t'(9'($urandom)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), {$urandom, $urandom},
          $urandom_range(0, 9) == 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RISC-V core, sitting directly downstream of the control unit and register-file read. Each cycle it captures the decoded control bundle (Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, ALUOp) plus operands and register indices for the EX stage. It also performs load-use hazard detection: it stalls PC and IF/ID and inserts a bubble into EX. It accepts a flush from branch/jump resolution.

## Interface
- XLEN, 64, datapath width (PC, operands, immediate)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jump  in  1 each  control-unit outputs
- id_alu_op  in  2  control-unit ALUOp
- id_pc  in  XLEN  PC of ID instruction
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  register-file reads, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct4  in  4  {instr[30], instr[14:12]}
- flush  in  1  squash the ID instruction (taken branch/jump)
- ex_* outputs  out  same widths as id_*  registered copies, plus ex_valid (1)
- pc_write  out  1  0 = hold PC this cycle
- if_id_write  out  1  0 = hold IF/ID this cycle
- hazard_count  out  32  saturating count of load-use stalls

## Operation
- Hazard detect, combinational: hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
- Both rs1 and rs2 are always compared, including for I-type and jal. This is conservative and costs at most one extra cycle.
- Priority per cycle: reset > flush > hazard > normal.
- Normal: every ex_* field is loaded from its id_* counterpart. ex_valid <= id_valid. pc_write = if_id_write = 1.
- Hazard without flush: a bubble is loaded. pc_write = if_id_write = 0. hazard_count increments, saturating at 0xFFFF_FFFF.
- Flush: a bubble is loaded. pc_write = if_id_write = 1, so the stall is suppressed because fetch is being redirected. hazard_count does not increment.
- Bubble: ex_valid and all seven 1-bit control outputs and ex_alu_op are 0. Datapath fields (pc, data, imm, rs/rd, funct4) may hold any value; ex_rd is forced to 0.
- id_valid = 0 in the normal case produces a bubble-equivalent: all control outputs are gated to 0.
- X values from the control unit on an invalid opcode are registered unchanged when id_valid = 1. Qualifying them is the decoder's responsibility.
- A stall is inherently one cycle: the inserted bubble clears ex_mem_read, so the held instruction proceeds the next cycle.

## Timing
- Latency: ID inputs appear on ex_* one cycle after the capturing edge.
- pc_write, if_id_write and hazard are combinational from registered ex_* state and current id_* inputs, with no added register. Downstream must sample them on the same edge.
- Reset (synchronous): ex_valid = 0, all control outputs = 0, ex_alu_op = 0, ex_rd/rs1/rs2 = 0, data fields = 0, hazard_count = 0.
- During reset, pc_write = if_id_write = 1. Because ex_valid = 0, hazard = 0 in the cycle after reset.
- Reset asserted mid-stall: the next state is the reset state and the stall is dropped.

## Structure
- Shared package (core-wide): ctrl_t struct holding the seven control bits and alu_op, CTRL_BUBBLE constant (all zero), ALUOp encodings (00 add, 01 branch-compare, 10 R-type, 11 I-type), XLEN.
- One natural sub-module: hazard_detect. It is purely combinational, takes ex_mem_read, ex_rd, ex_valid, id_rs1, id_rs2 and id_valid, and produces hazard.
- The pipeline register and hazard counter live in id_ex_stage.

## Test plan
- Reset: hold reset 2 cycles with id_valid = 1, R-type inputs → ex_valid = 0, all control 0, hazard_count = 0, pc_write = 1.
- Pass-through: R-type (reg_write = 1, alu_op = 10, rd = 5, rs1_data = 0x10) → next cycle ex_reg_write = 1, ex_alu_op = 10, ex_rd = 5, ex_rs1_data = 0x10, ex_valid = 1.
- Load-use: ld x6 followed by add rs1 = x6 → during the add's ID cycle pc_write = if_id_write = 0 and next ex_valid = 0. The following cycle the add enters EX. hazard_count = 1.
- No hazard on x0: ld rd = x0 followed by add rs1 = x0 → no stall, hazard_count unchanged.
- Flush during hazard: ld x7 in EX, ID instruction reads x7, flush = 1 → bubble loaded, pc_write = 1, hazard_count unchanged.
- Saturation: preload hazard_count near 0xFFFF_FFFF via repeated stalls (or force) → value stays at 0xFFFF_FFFF.
